// File: rtl/io_pkg.sv
// io_pkg: I/O window tag, register offsets and load-width encodings shared by the I/O responder
package io_pkg;
  localparam logic [5:0] IO_TAG = 6'h3C;
  localparam logic [9:0] IO_SW  = 10'h000;
  localparam logic [9:0] IO_BTN = 10'h004;
  localparam logic [9:0] IO_LED = 10'h010;
  localparam logic [9:0] IO_SEG = 10'h020;
  typedef enum logic [1:0] {BW_LB = 2'b00, BW_LW = 2'b01, BW_LBU = 2'b10} bw_e;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: stable output follows d only after d holds constant for CYCLES consecutive cycles
module io_debounce #(
  parameter int W = 1,
  parameter int CYCLES = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [W-1:0] last;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= '0;
      cnt <= '0;
      q <= '0;
    end else if (d != last) begin
      last <= d;
      cnt <= '0;
    end else if (cnt != CW'(CYCLES)) cnt <= cnt + CW'(1);
    else q <= last;
  end
endmodule

// File: rtl/io_mmio_responder.sv
// io_mmio_responder: I/O window responder (SW/BTN/LED/SEG registers, 1-cycle reads); define IO_DEBOUNCE_EN to debounce sw_i/btn_i
module io_mmio_responder
  import io_pkg::*;
#(
  parameter int SW_W = 16,
  parameter int LED_W = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             io_read_i,
  input  logic             io_write_i,
  input  logic [9:0]       addr_i,
  input  logic [1:0]       byte_or_word_i,
  input  logic [31:0]      wdata_i,
  input  logic [SW_W-1:0]  sw_i,
  input  logic             btn_i,
  output logic [31:0]      io_rdata_o,
  output logic             io_rvalid_o,
  output logic [LED_W-1:0] led_o,
  output logic [31:0]      seg_value_o
);
  logic [SW_W-1:0] sw_s1, sw_s2, sw_stable;
  logic btn_s1, btn_s2, btn_stable, btn_prev, btn_flag, rd, btn_rise;
  logic [9:0] off;
  logic [31:0] word, shaped;
`ifdef IO_DEBOUNCE_EN
  io_debounce #(.W(SW_W), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (.clk(clk_i), .rst(rst_i), .d(sw_s2), .q(sw_stable));
  io_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (.clk(clk_i), .rst(rst_i), .d(btn_s2), .q(btn_stable));
`else
  assign sw_stable = sw_s2;
  assign btn_stable = btn_s2;
`endif
  assign off = addr_i & 10'h3FC;
  assign rd = io_read_i & ~io_write_i;
  assign btn_rise = btn_stable & ~btn_prev;
  always_comb begin
    word = off == IO_SW ? 32'(sw_stable) : off == IO_BTN ? {31'b0, btn_flag} :
           off == IO_LED ? 32'(led_o) : off == IO_SEG ? seg_value_o : 32'b0;
    shaped = byte_or_word_i == BW_LB ? {{24{word[7]}}, word[7:0]} :
             byte_or_word_i == BW_LBU ? {24'b0, word[7:0]} : word;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_prev <= 1'b0;
      btn_flag <= 1'b0;
      io_rvalid_o <= 1'b0;
      io_rdata_o <= '0;
      led_o <= '0;
      seg_value_o <= '0;
    end else begin
      sw_s1 <= sw_i;
      sw_s2 <= sw_s1;
      btn_s1 <= btn_i;
      btn_s2 <= btn_s1;
      btn_prev <= btn_stable;
      btn_flag <= btn_rise | (btn_flag & ~(rd & (off == IO_BTN)));
      io_rvalid_o <= rd;
      if (rd) io_rdata_o <= shaped;
      if (io_write_i && off == IO_LED) led_o <= wdata_i[LED_W-1:0];
      if (io_write_i && off == IO_SEG) seg_value_o <= wdata_i;
    end
  end
endmodule

// File: tb/tb_io_mmio_responder.sv
// tb_io_mmio_responder: directed self-checking bench for io_mmio_responder
module tb_io_mmio_responder;
  logic clk = 1'b0, rst = 1'b1, io_read = 1'b0, io_write = 1'b0, btn = 1'b0, io_rvalid;
  logic [9:0] addr = '0;
  logic [1:0] bw = 2'b01;
  logic [31:0] wdata = '0, io_rdata, seg_value, d;
  logic [15:0] sw = '0, led;
  logic v;
  int total = 0, bad = 0;
  io_mmio_responder #(.SW_W(16), .LED_W(16), .DEBOUNCE_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .io_read_i(io_read), .io_write_i(io_write), .addr_i(addr),
    .byte_or_word_i(bw), .wdata_i(wdata), .sw_i(sw), .btn_i(btn), .io_rdata_o(io_rdata),
    .io_rvalid_o(io_rvalid), .led_o(led), .seg_value_o(seg_value));
  always #5 clk = ~clk;
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_read(input logic [9:0] a, input logic [1:0] b, output logic [31:0] rd, output logic rv);
    io_read = 1'b1;
    addr = a;
    bw = b;
    step(1);
    io_read = 1'b0;
    rd = io_rdata;
    rv = io_rvalid;
  endtask
  task automatic do_write(input logic [9:0] a, input logic [31:0] wd);
    io_write = 1'b1;
    addr = a;
    bw = 2'b01;
    wdata = wd;
    step(1);
    io_write = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    total += 3;
    if (led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0000", led); end
    if (seg_value !== 32'h0) begin bad++; $display("FAIL reset_seg got=%h exp=00000000", seg_value); end
    if (io_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", io_rvalid); end
    do_read(10'h004, 2'b01, d, v);
    total++;
    if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL reset_btn got=%h/%b exp=00000000/1", d, v); end
  endtask
  task automatic test_led;
    do_write(10'h010, 32'hFFFF_A5C3);
    total++;
    if (led !== 16'hA5C3) begin bad++; $display("FAIL led_out got=%h exp=a5c3", led); end
    total++;
    if (io_rvalid !== 1'b0) begin bad++; $display("FAIL write_no_rvalid got=%b exp=0", io_rvalid); end
    do_read(10'h010, 2'b01, d, v);
    total++;
    if (d !== 32'h0000_A5C3 || v !== 1'b1) begin bad++; $display("FAIL led_lw got=%h/%b exp=0000a5c3/1", d, v); end
    step(1);
    total++;
    if (io_rvalid !== 1'b0 || io_rdata !== 32'h0000_A5C3) begin bad++; $display("FAIL rdata_hold got=%h/%b exp=0000a5c3/0", io_rdata, io_rvalid); end
  endtask
  task automatic test_seg;
    do_write(10'h022, 32'h1234_56F8);
    total++;
    if (seg_value !== 32'h1234_56F8) begin bad++; $display("FAIL seg_out got=%h exp=123456f8", seg_value); end
    do_read(10'h020, 2'b00, d, v);
    total++;
    if (d !== 32'hFFFF_FFF8) begin bad++; $display("FAIL seg_lb got=%h exp=fffffff8", d); end
    do_read(10'h020, 2'b11, d, v);
    total++;
    if (d !== 32'h1234_56F8) begin bad++; $display("FAIL seg_bw11 got=%h exp=123456f8", d); end
  endtask
  task automatic test_sw;
    sw = 16'h0080;
    step(30);
    do_read(10'h000, 2'b00, d, v);
    total++;
    if (d !== 32'hFFFF_FF80) begin bad++; $display("FAIL sw_lb got=%h exp=ffffff80", d); end
    do_read(10'h000, 2'b10, d, v);
    total++;
    if (d !== 32'h0000_0080) begin bad++; $display("FAIL sw_lbu got=%h exp=00000080", d); end
    do_read(10'h000, 2'b01, d, v);
    total++;
    if (d !== 32'h0000_0080) begin bad++; $display("FAIL sw_lw got=%h exp=00000080", d); end
  endtask
  task automatic test_btn;
    btn = 1'b1;
    step(30);
    do_read(10'h004, 2'b01, d, v);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL btn_first got=%h exp=00000001", d); end
    do_read(10'h004, 2'b01, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL btn_cleared got=%h exp=00000000", d); end
    btn = 1'b0;
    step(30);
`ifndef IO_DEBOUNCE_EN
    btn = 1'b1;
    step(2);
    do_read(10'h004, 2'b01, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL btn_coincide got=%h exp=00000000", d); end
    do_read(10'h004, 2'b01, d, v);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL btn_kept got=%h exp=00000001", d); end
    btn = 1'b0;
    step(5);
`endif
  endtask
  task automatic test_unmapped;
    do_read(10'h3FC, 2'b01, d, v);
    total++;
    if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL unmapped_rd got=%h/%b exp=00000000/1", d, v); end
    do_write(10'h000, 32'hDEAD_BEEF);
    do_write(10'h3F0, 32'h0000_1111);
    total++;
    if (led !== 16'hA5C3) begin bad++; $display("FAIL ro_write_led got=%h exp=a5c3", led); end
    do_read(10'h000, 2'b01, d, v);
    total++;
    if (d !== 32'h0000_0080) begin bad++; $display("FAIL ro_write_sw got=%h exp=00000080", d); end
    io_read = 1'b1;
    io_write = 1'b1;
    addr = 10'h010;
    wdata = 32'h0000_3C3C;
    step(1);
    io_read = 1'b0;
    io_write = 1'b0;
    total++;
    if (io_rvalid !== 1'b0 || led !== 16'h3C3C) begin bad++; $display("FAIL rw_same got=%b/%h exp=0/3c3c", io_rvalid, led); end
    io_read = 1'b1;
    rst = 1'b1;
    addr = 10'h000;
    step(1);
    io_read = 1'b0;
    rst = 1'b0;
    total++;
    if (io_rvalid !== 1'b0 || led !== 16'h0) begin bad++; $display("FAIL rst_mid got=%b/%h exp=0/0000", io_rvalid, led); end
    step(30);
  endtask
  task automatic test_debounce;
`ifdef IO_DEBOUNCE_EN
    sw = 16'h0001;
    step(3);
    sw = 16'h0080;
    step(20);
    do_read(10'h000, 2'b01, d, v);
    total++;
    if (d !== 32'h0000_0080) begin bad++; $display("FAIL db_glitch got=%h exp=00000080", d); end
    sw = 16'h0001;
    step(5);
    do_read(10'h000, 2'b01, d, v);
    total++;
    if (d !== 32'h0000_0080) begin bad++; $display("FAIL db_early got=%h exp=00000080", d); end
    step(8);
    do_read(10'h000, 2'b01, d, v);
    total++;
    if (d !== 32'h0000_0001) begin bad++; $display("FAIL db_hold got=%h exp=00000001", d); end
`endif
  endtask
  initial begin
    step(1);
    test_reset;
    test_led;
    test_seg;
    test_sw;
    test_btn;
    test_unmapped;
    test_debounce;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
